// File: rtl/lab2_pkg.sv
// ----------------------------------------------------------------------------
// lab2_pkg
// Shared definitions for the lab2 response checker:
//   - VEC_W     : width of the stimulus vector and of the DUT response
//   - CNT_W     : width of the accept counter and of the error counter
//   - TABLE_LEN : number of entries in the golden response table
//   - state_t   : checker FSM state encoding (IDLE / RUN / DONE)
//   - sat_inc   : saturating increment used by the error counter
// ----------------------------------------------------------------------------
package lab2_pkg;

    localparam int VEC_W     = 4;
    localparam int CNT_W     = 5;
    localparam int TABLE_LEN = 1 << VEC_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Increment that sticks at the largest count a legal run can produce.
    // With at most TABLE_LEN vectors per run the ceiling is never exceeded,
    // but the guard makes the "never wraps" property hold by construction.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] ceiling;
        ceiling = CNT_W'(TABLE_LEN);
        if (val >= ceiling) begin
            return ceiling;
        end
        return val + CNT_W'(1);
    endfunction

endpackage : lab2_pkg

// File: rtl/lab2_exp_rom.sv
// ----------------------------------------------------------------------------
// lab2_exp_rom
// Combinational golden-response lookup. The 64-bit EXP_TABLE parameter holds
// sixteen 4-bit expected responses; entry i lives in bits [4i+3:4i] with the
// K output at the MSB and N at the LSB.
//
// Ports
//   idx   in  [VEC_W-1:0]  stimulus vector {A,B,C,D} used as the table index
//   data  out [VEC_W-1:0]  expected response {K,L,M,N} for that stimulus
// ----------------------------------------------------------------------------
module lab2_exp_rom
    import lab2_pkg::*;
#(
    parameter logic [TABLE_LEN*VEC_W-1:0] EXP_TABLE = '0
) (
    input  logic [VEC_W-1:0] idx,
    output logic [VEC_W-1:0] data
);

    // Unpack the flat parameter into one word per entry so the lookup is a
    // plain array index rather than a variable part-select.
    logic [VEC_W-1:0] table_arr [TABLE_LEN];

    generate
        for (genvar gi = 0; gi < TABLE_LEN; gi++) begin : g_entry
            assign table_arr[gi] = EXP_TABLE[gi*VEC_W +: VEC_W];
        end
    endgenerate

    assign data = table_arr[idx];

endmodule : lab2_exp_rom

// File: rtl/lab2_response_checker.sv
// ----------------------------------------------------------------------------
// lab2_response_checker
// Compares the responses of a 4-input / 4-output circuit under test against a
// golden table. A run is opened by a one-cycle start pulse; the checker then
// accepts N_VECTORS stimulus/response pairs, which must arrive in ascending
// order 0,1,2,... Each accepted pair is checked for both the response value
// and the sequence position. The first failing pair is captured for
// debugging, failures are counted, and done/pass report the outcome until the
// next start or reset.
//
// Parameters
//   N_VECTORS  vectors per run, 1..16
//   EXP_TABLE  golden table, entry i = bits [4i+3:4i] = {K,L,M,N}
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse opening a run (ignored while running)
//   vec_valid  in   stimulus and response present this cycle
//   vec_in     in   [3:0] applied stimulus {A,B,C,D}
//   resp_in    in   [3:0] observed response {K,L,M,N}
//   vec_ready  out  checker accepts a vector this cycle (state is RUN)
//   busy       out  run in progress
//   done       out  run complete, held until next start or reset
//   pass       out  done with no failing vectors and no order error
//   err_count  out  [4:0] failing vectors in the current run
//   order_err  out  sticky: a vector arrived out of sequence this run
//   ff_valid   out  a first failure has been captured
//   ff_idx     out  [3:0] stimulus of the first failure
//   ff_got     out  [3:0] observed response of the first failure
//   ff_exp     out  [3:0] expected response of the first failure
// ----------------------------------------------------------------------------
module lab2_response_checker
    import lab2_pkg::*;
#(
    parameter int                          N_VECTORS = 16,
    parameter logic [TABLE_LEN*VEC_W-1:0]  EXP_TABLE = 64'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vec_valid,
    input  logic [VEC_W-1:0] vec_in,
    input  logic [VEC_W-1:0] resp_in,
    output logic             vec_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic             order_err,
    output logic             ff_valid,
    output logic [VEC_W-1:0] ff_idx,
    output logic [VEC_W-1:0] ff_got,
    output logic [VEC_W-1:0] ff_exp
);

    // Run length in counter width; the terminal comparison uses all five
    // bits so that a 16-vector run ends on count 16, not on a wrapped 0.
    localparam logic [CNT_W-1:0] RUN_LEN = CNT_W'(N_VECTORS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_reg;
    logic [CNT_W-1:0] acc_cnt_reg;
    logic [CNT_W-1:0] err_count_reg;
    logic             order_err_reg;
    logic             ff_valid_reg;
    logic [VEC_W-1:0] ff_idx_reg;
    logic [VEC_W-1:0] ff_got_reg;
    logic [VEC_W-1:0] ff_exp_reg;

    // ------------------------------------------------------------------
    // Golden lookup, indexed by the stimulus actually applied
    // ------------------------------------------------------------------
    logic [VEC_W-1:0] exp_resp;

    lab2_exp_rom #(
        .EXP_TABLE (EXP_TABLE)
    ) u_exp_rom (
        .idx  (vec_in),
        .data (exp_resp)
    );

    // ------------------------------------------------------------------
    // Per-handshake evaluation
    // ------------------------------------------------------------------
    logic             in_run;
    logic             handshake;
    logic             seq_err;
    logic             resp_err;
    logic             vec_fail;
    logic [CNT_W-1:0] acc_cnt_next;
    logic             run_start;

    assign in_run       = (state_reg == ST_RUN);
    assign handshake    = vec_valid && in_run;
    // Only the low four bits name a vector position; bit 4 is only ever set
    // on the final count, after which no further vector is accepted.
    assign seq_err      = (vec_in != acc_cnt_reg[VEC_W-1:0]);
    assign resp_err     = (resp_in != exp_resp);
    assign vec_fail     = seq_err || resp_err;
    assign acc_cnt_next = acc_cnt_reg + CNT_W'(1);
    // start is only honoured outside RUN; a vector presented in the same
    // cycle is never a handshake there, so it is dropped automatically.
    assign run_start    = start && !in_run;

    // ------------------------------------------------------------------
    // FSM and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            acc_cnt_reg   <= '0;
            err_count_reg <= '0;
            order_err_reg <= 1'b0;
            ff_valid_reg  <= 1'b0;
            ff_idx_reg    <= '0;
            ff_got_reg    <= '0;
            ff_exp_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (run_start) begin
                        state_reg     <= ST_RUN;
                        acc_cnt_reg   <= '0;
                        err_count_reg <= '0;
                        order_err_reg <= 1'b0;
                        ff_valid_reg  <= 1'b0;
                        ff_idx_reg    <= '0;
                        ff_got_reg    <= '0;
                        ff_exp_reg    <= '0;
                    end
                end

                ST_RUN: begin
                    if (handshake) begin
                        acc_cnt_reg <= acc_cnt_next;

                        if (seq_err) begin
                            order_err_reg <= 1'b1;
                        end

                        if (vec_fail) begin
                            err_count_reg <= sat_inc(err_count_reg);
                            // Keep the earliest failure; later ones only count.
                            if (!ff_valid_reg) begin
                                ff_valid_reg <= 1'b1;
                                ff_idx_reg   <= vec_in;
                                ff_got_reg   <= resp_in;
                                ff_exp_reg   <= exp_resp;
                            end
                        end

                        // Leaving RUN on the same edge as the last error update
                        // makes done and the final err_count appear together.
                        if (acc_cnt_next == RUN_LEN) begin
                            state_reg <= ST_DONE;
                        end
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decodes of registered state only
    // ------------------------------------------------------------------
    assign vec_ready = in_run;
    assign busy      = in_run;
    assign done      = (state_reg == ST_DONE);
    assign pass      = done && (err_count_reg == '0) && !order_err_reg;
    assign err_count = err_count_reg;
    assign order_err = order_err_reg;
    assign ff_valid  = ff_valid_reg;
    assign ff_idx    = ff_idx_reg;
    assign ff_got    = ff_got_reg;
    assign ff_exp    = ff_exp_reg;

endmodule : lab2_response_checker

// File: tb/tb_lab2_response_checker.sv
// ----------------------------------------------------------------------------
// tb_lab2_response_checker
// Directed bench for lab2_response_checker. Two instances share clock and
// reset:
//   dut   N_VECTORS=16, identity table (entry i = i)
//   dut4  N_VECTORS=4,  table entries 0..3 = 3, A, 5, C
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// ----------------------------------------------------------------------------
module tb_lab2_response_checker;

    localparam logic [63:0] TBL16 = 64'hFEDCBA9876543210;
    localparam logic [63:0] TBL4  = 64'h0000_0000_0000_C5A3;

    logic       clk;
    logic       rst_n;

    // Signals of the 16-vector instance
    logic       start;
    logic       vec_valid;
    logic [3:0] vec_in;
    logic [3:0] resp_in;
    logic       vec_ready;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic       order_err;
    logic       ff_valid;
    logic [3:0] ff_idx;
    logic [3:0] ff_got;
    logic [3:0] ff_exp;

    // Signals of the 4-vector instance
    logic       b_start;
    logic       b_vec_valid;
    logic [3:0] b_vec_in;
    logic [3:0] b_resp_in;
    logic       b_vec_ready;
    logic       b_busy;
    logic       b_done;
    logic       b_pass;
    logic [4:0] b_err_count;
    logic       b_order_err;
    logic       b_ff_valid;
    logic [3:0] b_ff_idx;
    logic [3:0] b_ff_got;
    logic [3:0] b_ff_exp;

    int n_checks = 0;
    int n_errors = 0;

    lab2_response_checker #(
        .N_VECTORS (16),
        .EXP_TABLE (TBL16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vec_valid (vec_valid),
        .vec_in    (vec_in),
        .resp_in   (resp_in),
        .vec_ready (vec_ready),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .order_err (order_err),
        .ff_valid  (ff_valid),
        .ff_idx    (ff_idx),
        .ff_got    (ff_got),
        .ff_exp    (ff_exp)
    );

    lab2_response_checker #(
        .N_VECTORS (4),
        .EXP_TABLE (TBL4)
    ) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (b_start),
        .vec_valid (b_vec_valid),
        .vec_in    (b_vec_in),
        .resp_in   (b_resp_in),
        .vec_ready (b_vec_ready),
        .busy      (b_busy),
        .done      (b_done),
        .pass      (b_pass),
        .err_count (b_err_count),
        .order_err (b_order_err),
        .ff_valid  (b_ff_valid),
        .ff_idx    (b_ff_idx),
        .ff_got    (b_ff_got),
        .ff_exp    (b_ff_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the directed sequence is a few hundred cycles long.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: got=%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send16(input logic [3:0] v, input logic [3:0] r);
        vec_valid = 1'b1;
        vec_in    = v;
        resp_in   = r;
        tick();
        vec_valid = 1'b0;
    endtask

    task automatic send4(input logic [3:0] v, input logic [3:0] r);
        b_vec_valid = 1'b1;
        b_vec_in    = v;
        b_resp_in   = r;
        tick();
        b_vec_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; vec_valid = 1'b0; vec_in = '0; resp_in = '0;
        b_start = 1'b0; b_vec_valid = 1'b0; b_vec_in = '0; b_resp_in = '0;

        // ---------------- reset state ----------------
        #3;
        check_eq("rst_vec_ready", vec_ready, 0);
        check_eq("rst_busy",      busy,      0);
        check_eq("rst_done",      done,      0);
        check_eq("rst_pass",      pass,      0);
        check_eq("rst_err_count", err_count, 0);
        check_eq("rst_order_err", order_err, 0);
        check_eq("rst_ff_valid",  ff_valid,  0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_idle_busy", busy, 0);

        // ---------------- backpressure in IDLE, then matching run ----------------
        vec_valid = 1'b1; vec_in = 4'h0; resp_in = 4'h0;
        repeat (5) tick();
        check_eq("idle_valid_err",   err_count, 0);
        check_eq("idle_valid_busy",  busy,      0);
        check_eq("idle_valid_ready", vec_ready, 0);
        check_eq("idle_valid_done",  done,      0);
        // start with vec_valid still high: that vector must not count
        pulse_start();
        check_eq("run1_busy",  busy,      1);
        check_eq("run1_ready", vec_ready, 1);
        for (int i = 0; i < 16; i++) begin
            send16(4'(i), 4'(i));
            if (i == 14) check_eq("run1_not_done_at_15", done, 0);
        end
        check_eq("run1_done",      done,      1);
        check_eq("run1_pass",      pass,      1);
        check_eq("run1_err",       err_count, 0);
        check_eq("run1_ff_valid",  ff_valid,  0);
        check_eq("run1_order_err", order_err, 0);
        check_eq("run1_busy_end",  busy,      0);

        // vec_valid in DONE is ignored and done holds
        vec_valid = 1'b1; vec_in = 4'h3; resp_in = 4'h9;
        repeat (3) tick();
        vec_valid = 1'b0;
        check_eq("done_hold_done", done,      1);
        check_eq("done_hold_err",  err_count, 0);
        check_eq("done_hold_pass", pass,      1);

        // ---------------- single mismatch on vector 5 ----------------
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                check_eq("mm_err_before", err_count, 0);
                send16(4'h5, 4'hA);
                check_eq("mm_err_after_1cyc", err_count, 1);
            end else begin
                send16(4'(i), 4'(i));
            end
        end
        check_eq("mm_done",     done,      1);
        check_eq("mm_err",      err_count, 1);
        check_eq("mm_ff_valid", ff_valid,  1);
        check_eq("mm_ff_idx",   ff_idx,    5);
        check_eq("mm_ff_got",   ff_got,    4'hA);
        check_eq("mm_ff_exp",   ff_exp,    5);
        check_eq("mm_order",    order_err, 0);
        check_eq("mm_pass",     pass,      0);

        // ---------------- restart from DONE ----------------
        pulse_start();
        check_eq("rs_err_clr",   err_count, 0);
        check_eq("rs_ffv_clr",   ff_valid,  0);
        check_eq("rs_ffidx_clr", ff_idx,    0);
        check_eq("rs_done_clr",  done,      0);
        check_eq("rs_busy",      busy,      1);
        // start pulsed during vector 8 must not restart the run
        for (int i = 0; i < 16; i++) begin
            if (i == 8) start = 1'b1;
            send16(4'(i), 4'(i));
            start = 1'b0;
        end
        check_eq("rs_done", done,      1);
        check_eq("rs_pass", pass,      1);
        check_eq("rs_err",  err_count, 0);

        // ---------------- reset mid-run ----------------
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            send16(4'(i), (i == 3) ? 4'h7 : 4'(i));
        end
        check_eq("mr_err_pre",  err_count, 1);
        check_eq("mr_ffv_pre",  ff_valid,  1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mr_rst_busy",  busy,      0);
        check_eq("mr_rst_ready", vec_ready, 0);
        check_eq("mr_rst_err",   err_count, 0);
        check_eq("mr_rst_ffv",   ff_valid,  0);
        check_eq("mr_rst_ffidx", ff_idx,    0);
        check_eq("mr_rst_ffgot", ff_got,    0);
        check_eq("mr_rst_ffexp", ff_exp,    0);
        check_eq("mr_rst_done",  done,      0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check_eq("mr_stay_idle", busy, 0);
        check_eq("mr_stay_done", done, 0);
        pulse_start();
        for (int i = 0; i < 16; i++) send16(4'(i), 4'(i));
        check_eq("mr_fresh_done", done,      1);
        check_eq("mr_fresh_pass", pass,      1);
        check_eq("mr_fresh_err",  err_count, 0);

        // ---------------- order error, N_VECTORS=4 ----------------
        b_start = 1'b1; tick(); b_start = 1'b0;
        check_eq("ord_busy", b_busy, 1);
        send4(4'h0, 4'h3);
        send4(4'h1, 4'hA);
        send4(4'h3, 4'hC);
        check_eq("ord_err_mid",   b_err_count, 1);
        check_eq("ord_order_mid", b_order_err, 1);
        check_eq("ord_not_done",  b_done,      0);
        send4(4'h2, 4'h5);
        check_eq("ord_done",     b_done,      1);
        check_eq("ord_err",      b_err_count, 2);
        check_eq("ord_order",    b_order_err, 1);
        check_eq("ord_ff_valid", b_ff_valid,  1);
        check_eq("ord_ff_idx",   b_ff_idx,    3);
        check_eq("ord_ff_got",   b_ff_got,    4'hC);
        check_eq("ord_ff_exp",   b_ff_exp,    4'hC);
        check_eq("ord_pass",     b_pass,      0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_lab2_response_checker

// File: doc/lab2_response_checker.md
LAB2_RESPONSE_CHECKER -- requirements
Module: lab2_response_checker

Interface
REQ-001 Parameter N_VECTORS, default 16, is the number of vectors per run; legal range 1..16.
REQ-002 Parameter EXP_TABLE, default 64'h0, is the golden response table: entry i is bits [4i+3:4i], with K at the MSB and N at the LSB.
REQ-003 clk  input  1  is the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  is the reset: asynchronous, active-low.
REQ-005 start  input  1  is a one-cycle pulse that begins a run.
REQ-006 vec_valid  input  1  signals that the stimulus vector and its response are present.
REQ-007 vec_in  input  4  is the applied stimulus {A,B,C,D}, with A at the MSB.
REQ-008 resp_in  input  4  is the observed DUT response {K,L,M,N}, with K at the MSB.
REQ-009 vec_ready  output  1  means the checker accepts a vector this cycle.
REQ-010 busy  output  1  means a run is in progress.
REQ-011 done  output  1  means the run is complete; it holds until the next start or reset.
REQ-012 pass  output  1  means done is asserted and no errors were recorded.
REQ-013 err_count  output  5  is the number of failing vectors in the current run.
REQ-014 order_err  output  1  is a sticky flag: a vector arrived out of sequence.
REQ-015 ff_valid, ff_idx[3:0], ff_got[3:0], ff_exp[3:0]  output  capture the first failing vector: valid flag, index, observed response, expected response.

Function
REQ-016 The checker SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-017 IDLE->RUN on start; DONE->RUN on start; start in RUN SHALL be ignored.
REQ-018 Entering RUN SHALL clear err_count, order_err, ff_* and the accept counter, and SHALL deassert done.
REQ-019 vec_ready SHALL equal (state==RUN); a handshake is vec_valid && vec_ready.
REQ-020 On a handshake, a vector fails if resp_in != EXP_TABLE[vec_in] or vec_in != accept counter[3:0].
REQ-021 A sequence mismatch SHALL set order_err.
REQ-022 A failing handshake SHALL increment err_count, registered: visible one cycle after the handshake.
REQ-023 The first failing handshake of a run SHALL load ff_idx=vec_in, ff_got=resp_in, ff_exp=EXP_TABLE[vec_in] and set ff_valid; later failures SHALL NOT overwrite these.
REQ-024 The handshake that makes the accept count equal N_VECTORS SHALL move the FSM to DONE; done asserts the next cycle, in the same cycle as that vector's err_count update.
REQ-025 pass SHALL equal done && (err_count==0) && !order_err.
REQ-026 err_count SHALL NOT exceed 16 (guaranteed by N_VECTORS<=16); no wrap.
REQ-027 The accept counter SHALL be 5 bits; the comparison against N_VECTORS uses all 5 bits.
REQ-028 vec_valid outside RUN SHALL be ignored with no state change.
REQ-029 start coincident with a handshake in DONE or IDLE SHALL start a run; the handshake is not counted.

Reset
REQ-030 rst_n low SHALL asynchronously force: state=IDLE, vec_ready=0, busy=0, done=0, pass=0, err_count=0, order_err=0, ff_valid=0, ff_idx=0, ff_got=0, ff_exp=0.
REQ-031 Reset asserted mid-run SHALL abort the run and discard all partial results.
REQ-032 After reset release, the block SHALL stay in IDLE until start.

Structure
REQ-033 The FSM state encoding and the widths (VEC_W=4, CNT_W=5) SHALL reside in the shared package lab2_pkg.
REQ-034 The golden lookup SHALL be the sub-module lab2_exp_rom: combinational, 4-bit index in, 4-bit expected value out, parameterised by EXP_TABLE.

Verification
REQ-035 Matching run: EXP_TABLE=64'hFEDCBA9876543210, start, then 16 in-order vectors with resp_in=vec_in -> done=1, pass=1, err_count=0, ff_valid=0.
REQ-036 Single mismatch: same table, vector 5 sent with resp_in=4'hA -> err_count=1, ff_idx=5, ff_got=A, ff_exp=5, pass=0.
REQ-037 Order error: N_VECTORS=4, vectors 0,1,3,2 with correct responses -> order_err=1, err_count=2, ff_idx=3.
REQ-038 Backpressure: vec_valid held high in IDLE for 5 cycles, then start -> no counts before start, run completes normally.
REQ-039 Reset mid-run: rst_n pulsed low after 7 handshakes -> all outputs 0 immediately; a following start runs 16 fresh vectors to pass=1.
REQ-040 Restart from DONE: after a failing run, start -> err_count, ff_valid, done cleared on the next cycle; clean run -> pass=1.
